// File: rtl/subword_store_unit.sv
// Sub-word store unit: turns SW/SH/SB requests into aligned word writes.
// Byte and halfword stores are done as a read-modify-write of the containing word.
module subword_store_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_SW = 2'b00;
  localparam logic [1:0] OP_SH = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [31:0] rbuf_p1;
  logic        accept;

  function automatic logic misaligned(input logic [1:0] op, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_SW:   bad = (lo != 2'b00);
      OP_SH:   bad = lo[0];
      OP_SB:   bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Truncating merge: only the addressed lane(s) change, no extension applied.
  function automatic logic [31:0] merge_word(input logic [1:0]  op,
                                             input logic [1:0]  lo,
                                             input logic [31:0] old_word,
                                             input logic [31:0] wd);
    logic [31:0] w;
    w = old_word;
    if (op == OP_SB) begin
      case (lo)
        2'd0: w[7:0]   = wd[7:0];
        2'd1: w[15:8]  = wd[7:0];
        2'd2: w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end else if (op == OP_SH) begin
      if (lo[1]) w[31:16] = wd[15:0];
      else       w[15:0]  = wd[15:0];
    end else begin
      w = wd;
    end
    return w;
  endfunction

  assign accept = (state == IDLE) && req_valid;

  // Request capture (p0) and read-data capture (p1)
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state    <= IDLE;
      op_p0    <= 2'b00;
      addr_p0  <= 32'd0;
      wdata_p0 <= 32'd0;
      rbuf_p1  <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_p0    <= req_op;
        addr_p0  <= req_addr;
        wdata_p0 <= req_wdata;
      end
      if (state == MERGE) begin
        rbuf_p1 <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_addr  = 32'd0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = 32'd0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned(req_op, req_addr[1:0])) state_nxt = ERR;
          else if (req_op == OP_SW)              state_nxt = WRITE;
          else                                   state_nxt = READ;
        end
      end
      READ: begin
        mem_addr  = {addr_p0[31:2], 2'b00};
        mem_rd_en = 1'b1;
        state_nxt = MERGE;
      end
      MERGE: begin
        mem_addr  = {addr_p0[31:2], 2'b00};
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_addr  = {addr_p0[31:2], 2'b00};
        mem_wr_en = 1'b1;
        mem_wdata = merge_word(op_p0, addr_p0[1:0], rbuf_p1, wdata_p0);
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        done      = 1'b1;
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_subword_store_unit.sv
// Directed bench for subword_store_unit with a write scoreboard and a one-cycle read memory model.
module tb_subword_store_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [31:0] mem_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  int done_exp  = 0;
  logic [31:0] rd_word = 32'd0;
  logic [63:0] wr_q[$];

  subword_store_unit dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  initial mem_rdata = 32'd0;
  always @(posedge Clk) if (mem_rd_en) mem_rdata <= rd_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard, in order.
  always @(negedge Clk) begin
    if (Rst === 1'b1 && (mem_rd_en === 1'b1 || mem_wr_en === 1'b1))
      chk("rd_wr_exclusive", {31'd0, mem_rd_en & mem_wr_en}, 32'd0);
    if (Rst === 1'b1 && done === 1'b1) done_seen++;
    if (mem_wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = wr_q.pop_front();
        chk("sb_addr", mem_addr, e[63:32]);
        chk("sb_data", mem_wdata, e[31:0]);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic sub_store(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] rd, input logic [31:0] exp);
    rd_word = rd;
    wr_q.push_back({{a[31:2], 2'b00}, exp});
    done_exp++;
    send(op, a, d);
    chk({tag, "_c1_rd"}, {31'd0, mem_rd_en}, 32'd1);
    chk({tag, "_c1_addr"}, mem_addr, {a[31:2], 2'b00});
    chk({tag, "_c1_done"}, {31'd0, done}, 32'd0);
    step();
    chk({tag, "_c2_rdwr"}, {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk({tag, "_c2_wdata"}, mem_wdata, 32'd0);
    step();
    chk({tag, "_c3_wr_done"}, {30'd0, mem_wr_en, done}, 32'd3);
    chk({tag, "_c3_wdata"}, mem_wdata, exp);
    step();
    chk({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic bad_store(input string tag, input logic [1:0] op, input logic [31:0] a);
    done_exp++;
    send(op, a, 32'h1234_5678);
    chk({tag, "_err_done"}, {30'd0, err, done}, 32'd3);
    chk({tag, "_no_strobe"}, {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk({tag, "_addr0"}, mem_addr, 32'd0);
    step();
    chk({tag, "_after"}, {29'd0, req_ready, err, done}, 32'd4);
  endtask

  initial begin
    Rst = 1'b0;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    step();
    step();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_strobes", {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    Rst = 1'b1;
    step();

    // Aligned SW
    wr_q.push_back({32'h10, 32'hDEAD_BEEF});
    done_exp++;
    send(2'b00, 32'h10, 32'hDEAD_BEEF);
    chk("sw_wr_done", {29'd0, mem_rd_en, mem_wr_en, done}, 32'd3);
    chk("sw_addr", mem_addr, 32'h10);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_busy", {31'd0, req_ready}, 32'd0);
    step();
    chk("sw_after", {29'd0, req_ready, mem_wr_en, done}, 32'd4);
    chk("sw_after_wdata", mem_wdata, 32'd0);

    sub_store("sb_lane3", 2'b10, 32'h13, 32'h0000_00AB, 32'h1122_3344, 32'hAB22_3344);
    sub_store("sh_hi",    2'b01, 32'h22, 32'hFFFF_8001, 32'hCAFE_F00D, 32'h8001_F00D);
    sub_store("sb_lane0", 2'b10, 32'h40, 32'h1234_56CD, 32'hAAAA_AAAA, 32'hAAAA_AACD);
    sub_store("sh_lo",    2'b01, 32'h44, 32'h0000_BEEF, 32'h1234_5678, 32'h1234_BEEF);

    bad_store("sh_odd", 2'b01, 32'h05);
    bad_store("sw_mis", 2'b00, 32'h06);
    bad_store("op_rsv", 2'b11, 32'h08);

    // Request held valid across a busy SB: second one waits for IDLE
    rd_word = 32'd0;
    wr_q.push_back({32'h30, 32'h0000_5500});
    wr_q.push_back({32'h80, 32'h0102_0304});
    done_exp += 2;
    req_valid = 1'b1;
    req_op = 2'b10;
    req_addr = 32'h31;
    req_wdata = 32'h0000_0055;
    step();
    req_op = 2'b00;
    req_addr = 32'h80;
    req_wdata = 32'h0102_0304;
    chk("b2b_c1_busy", {30'd0, req_ready, mem_rd_en}, 32'd1);
    step();
    chk("b2b_c2_busy", {31'd0, req_ready}, 32'd0);
    step();
    chk("b2b_c3_write", {29'd0, req_ready, mem_wr_en, done}, 32'd3);
    chk("b2b_c3_addr", mem_addr, 32'h30);
    step();
    chk("b2b_c4_idle", {29'd0, req_ready, mem_wr_en, done}, 32'd4);
    step();
    req_valid = 1'b0;
    chk("b2b_c5_sw", {29'd0, req_ready, mem_wr_en, done}, 32'd3);
    chk("b2b_c5_addr", mem_addr, 32'h80);
    step();

    // Reset during MERGE aborts the store
    rd_word = 32'h5555_5555;
    send(2'b10, 32'h50, 32'h0000_00EE);
    step();
    chk("rstm_merge", {30'd0, mem_rd_en, mem_wr_en}, 32'd0);
    chk("rstm_merge_addr", mem_addr, 32'h50);
    Rst = 1'b0;
    step();
    chk("rstm_no_wr_done", {30'd0, mem_wr_en, done}, 32'd0);
    Rst = 1'b1;
    step();
    chk("rstm_ready", {31'd0, req_ready}, 32'd1);
    chk("rstm_quiet", {28'd0, mem_rd_en, mem_wr_en, done, err}, 32'd0);
    step();
    step();

    chk("queue_drained", wr_q.size(), 32'd0);
    chk("done_count", done_seen, done_exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subword_store_unit.md
SUBWORD_STORE_UNIT -- requirements
Module: subword_store_unit

Interface
REQ-001 The block SHALL have exactly one clock, Clk, and a synchronous active-low reset, Rst, sampled on the rising edge of Clk.
REQ-002 The block SHALL have no parameters; all widths are fixed.
REQ-003 The ports SHALL be as follows, each line giving name, direction, width and meaning:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_op  in  2  00=SW (word), 01=SH (halfword), 10=SB (byte), 11=reserved
- req_addr  in  32  byte address
- req_wdata  in  32  store data; SH uses [15:0], SB uses [7:0]
- mem_addr  out  32  word address to data memory, {addr[31:2],2'b00}
- mem_rd_en  out  1  memory read strobe
- mem_rdata  in  32  memory read data, valid the cycle after mem_rd_en
- mem_wr_en  out  1  memory write strobe
- mem_wdata  out  32  full word written to memory
- done  out  1  one-cycle pulse when the request completes
- err  out  1  one-cycle pulse, coincident with done, on a rejected request

Function
REQ-004 The FSM SHALL have the states IDLE, READ, MERGE, WRITE and ERR.
REQ-005 A request SHALL be accepted on a rising edge only when req_valid=1 and req_ready=1; at acceptance req_op, req_addr and req_wdata SHALL be registered.
REQ-006 req_ready SHALL be 1 in IDLE and 0 in every other state; requests presented while not in IDLE SHALL be ignored, not queued.
REQ-007 The alignment check SHALL reject a request when: SW has addr[1:0]!=00; SH has addr[0]=1; or op=11.
REQ-008 A rejected request SHALL go IDLE->ERR; ERR SHALL assert err=1 and done=1 for one cycle, then return to IDLE, with no memory strobe asserted.
REQ-009 An aligned SW SHALL go IDLE->WRITE; WRITE SHALL assert mem_wr_en=1, mem_wdata=registered wdata and done=1, then return to IDLE (latency 1 cycle after acceptance).
REQ-010 An aligned SH or SB SHALL go IDLE->READ->MERGE->WRITE->IDLE:
- READ asserts mem_rd_en=1.
- MERGE captures mem_rdata into a word buffer.
- WRITE asserts mem_wr_en=1 and done=1 with the merged word.
- Latency is 3 cycles after acceptance.
REQ-011 Byte lanes SHALL be little-endian. For SB, lane addr[1:0]=k occupies bits [8k+7:8k]. For SH, addr[1]=0 selects [15:0] and addr[1]=1 selects [31:16].
REQ-012 The merge SHALL replace only the selected lane(s) with the low bits of the registered wdata; all other bits SHALL come unchanged from the captured mem_rdata. This is truncation, the inverse of load-side sign/zero extension, and no extension SHALL be applied on the store path.
REQ-013 mem_addr SHALL hold the registered word address for READ, MERGE and WRITE, and SHALL be 0 in IDLE and ERR.
REQ-014 mem_rd_en and mem_wr_en SHALL never be asserted in the same cycle.
REQ-015 done SHALL be high for exactly one cycle per accepted request.
REQ-016 A new request SHALL be acceptable on the cycle after done; back-to-back throughput is therefore one SW per 2 cycles and one SB/SH per 4 cycles.
REQ-017 mem_wdata SHALL be 0 in every state except WRITE.

Reset
REQ-018 While Rst=0 at a rising edge, the state SHALL become IDLE, and all registers, including the captured request and word buffer, SHALL clear to 0.
REQ-019 After reset the output values SHALL be: req_ready=1, and mem_addr, mem_rd_en, mem_wr_en, mem_wdata, done and err all 0.
REQ-020 Reset asserted in READ, MERGE or WRITE SHALL abort the request, with no write and no done issued; if reset coincides with WRITE, the WRITE cycle's outputs are still driven combinationally in that cycle but the request is not retried.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- SW addr=0x0000_0010, wdata=0xDEADBEEF -> 1 cycle later: mem_wr_en=1, mem_addr=0x10, mem_wdata=0xDEADBEEF, done=1, mem_rd_en never asserted.
- SB addr=0x0000_0013, wdata=0x0000_00AB, mem_rdata=0x11223344 -> READ at mem_addr=0x10, then write 0xAB223344 with done 3 cycles after acceptance.
- SH addr=0x0000_0022, wdata=0xFFFF_8001, mem_rdata=0xCAFEF00D -> write 0x8001F00D to mem_addr=0x20.
- SH addr=0x0000_0005 and SW addr=0x0000_0006 -> each gives err=1 and done=1 one cycle after acceptance, with no mem_rd_en or mem_wr_en.
- req_valid held high during a busy SB -> second request accepted only on the cycle after done; two writes observed, in order.
- Rst=0 asserted in MERGE -> no mem_wr_en and no done; the next cycle after release shows req_ready=1.
